// File: rtl/global_pkg.sv
// global_pkg: shared system constants and types.
// Holds the UART clocking constants and the receiver FSM state type.
package global_pkg;

  localparam int FREQ_CLK = 100000000;
  localparam int TX_SPEED = 115200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: RXD synchronizer, falling-edge detect, sample line.
// UART_RX_MAJORITY_EN votes the sample over the last 3 synced values.
module uart_rx_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic rxd,
  output logic line,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      prev <= s2;
      fall <= prev & ~s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic prev2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev2 <= 1'b1;
    end else begin
      prev2 <= prev;
    end
  end

  assign line = (s2 & prev) | (s2 & prev2) | (prev & prev2);
`else
  assign line = s2;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver presenting bytes on a valid/ack port.
// Build option: UART_RX_MAJORITY_EN enables 3-sample majority voting.
module uart_rx #(
  parameter int FREQ_CLK = global_pkg::FREQ_CLK,
  parameter int TX_SPEED = global_pkg::TX_SPEED
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RXD,
  output logic [7:0] Data_Out,
  output logic       Data_Valid,
  input  logic       Data_Ack,
  output logic       Frame_Error,
  output logic       Overrun
);

  import global_pkg::*;

  localparam int BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);

  uart_rx_state_t state;
  uart_rx_state_t state_n;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          line;
  logic          fall;
  logic          bit_hit;
  logic          half_hit;
  logic          stop_hit;

  uart_rx_sync u_sync (
    .Clk  (Clk),
    .Rst  (Rst),
    .rxd  (RXD),
    .line (line),
    .fall (fall)
  );

  assign bit_hit  = (cnt == BIT_M1);
  assign half_hit = (cnt == HALF_M1);
  assign stop_hit = (state == STOP) && bit_hit;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (fall) state_n = START;
      START:   if (half_hit) state_n = line ? IDLE : DATA;
      DATA:    if (bit_hit && idx == 3'd7) state_n = STOP;
      STOP:    if (bit_hit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == IDLE || bit_hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == START) begin
        idx <= '0;
      end else if (state == DATA && bit_hit) begin
        shreg[idx] <= line;
        idx        <= idx + 3'd1;
      end
    end
  end

  // A finished byte may replace the held one only when it is acked now.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Data_Out    <= '0;
      Data_Valid  <= 1'b0;
      Frame_Error <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      Frame_Error <= stop_hit && !line;
      Overrun     <= 1'b0;
      if (Data_Valid && Data_Ack) begin
        Data_Valid <= 1'b0;
      end
      if (stop_hit && line) begin
        if (!Data_Valid || Data_Ack) begin
          Data_Out   <= shreg;
          Data_Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at a reduced clock rate.
// Bit time is 100 clocks so the run stays short.
module tb_uart_rx;

  localparam int FCLK = 11520000;
  localparam int BAUD = 115200;
  localparam int BC   = FCLK / BAUD;
  localparam int HALF = BC / 2;
  localparam int LAT  = HALF + 9 * BC + 3;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       RXD;
  logic       Data_Ack;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Frame_Error;
  logic       Overrun;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vr_cnt = 0;
  logic dv_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .FREQ_CLK (FCLK),
    .TX_SPEED (BAUD)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .RXD         (RXD),
    .Data_Out    (Data_Out),
    .Data_Valid  (Data_Valid),
    .Data_Ack    (Data_Ack),
    .Frame_Error (Frame_Error),
    .Overrun     (Overrun)
  );

  initial forever #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, errors=%0d", errors);
    $fatal(1);
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (Frame_Error === 1'b1) fe_cnt++;
    if (Overrun === 1'b1) ov_cnt++;
    if (Data_Valid === 1'b1 && dv_q !== 1'b1) vr_cnt++;
    dv_q = Data_Valid;
  end

  task automatic drive_frame(input logic [7:0] b, input logic stop_b);
    @(negedge Clk);
    RXD = 1'b0;
    repeat (BC) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (BC) @(negedge Clk);
    end
    RXD = stop_b;
    repeat (BC) @(negedge Clk);
    RXD = 1'b1;
  endtask

  task automatic wait_frame(input bit ack_done, output logic vb,
                            output logic va, output logic [7:0] d,
                            output logic fe, output logic ov);
    wait (RXD === 1'b0);
    @(posedge Clk);
    repeat (LAT - 1) @(posedge Clk);
    #1;
    vb = Data_Valid;
    if (ack_done) Data_Ack = 1'b1;
    @(posedge Clk);
    #1;
    va = Data_Valid;
    d  = Data_Out;
    fe = Frame_Error;
    ov = Overrun;
    if (ack_done) Data_Ack = 1'b0;
  endtask

  task automatic take_exp(output logic [7:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    RXD = 1'b1;
    Data_Ack = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Data_Out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", Data_Out);
    end
    checks++;
    if ({Data_Valid, Frame_Error, Overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {Data_Valid, Frame_Error, Overrun});
    end
    @(negedge Clk);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_single();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    exp_q.push_back(8'hAB);
    fork
      drive_frame(8'hAB, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    take_exp(e);
    checks++;
    if ({vb, va} !== 2'b01) begin
      errors++;
      $display("FAIL single_latency: got %b expected 01", {vb, va});
    end
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", d, e);
    end
    repeat (50) @(negedge Clk);
    checks++;
    if ({Data_Valid, Data_Out} !== {1'b1, 8'hAB}) begin
      errors++;
      $display("FAIL single_hold: got %b/%h expected 1/ab",
               Data_Valid, Data_Out);
    end
    Data_Ack = 1'b1;
    @(posedge Clk);
    #1;
    Data_Ack = 1'b0;
    checks++;
    if (Data_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_clear: got %b expected 0", Data_Valid);
    end
  endtask

  task automatic test_back_to_back();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    int fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    fork
      begin
        drive_frame(8'hAB, 1'b1);
        drive_frame(8'hCD, 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
        wait_frame(1'b0, vb, va, d, fe, ov);
        take_exp(e);
        checks++;
        if ({va, d} !== {1'b1, e}) begin
          errors++;
          $display("FAIL b2b_byte%0d: got %b/%h expected 1/%h",
                   k, va, d, e);
        end
        Data_Ack = 1'b1;
        @(posedge Clk);
        #1;
        Data_Ack = 1'b0;
        checks++;
        if (Data_Valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_clear%0d: got %b expected 0", k, Data_Valid);
        end
      end
    join
    repeat (5) @(negedge Clk);
    checks++;
    if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin
      errors++;
      $display("FAIL b2b_flags: got fe=%0d ov=%0d expected 0/0",
               fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0, vr0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vr0 = vr_cnt;
    @(negedge Clk);
    RXD = 1'b0;
    repeat (20) @(negedge Clk);
    RXD = 1'b1;
    repeat (3) @(negedge Clk);
    Data_Ack = 1'b1;
    @(negedge Clk);
    Data_Ack = 1'b0;
    repeat (12 * BC) @(negedge Clk);
    checks++;
    if (vr_cnt - vr0 !== 0 || Data_Valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_valid: got %0d rises expected 0",
               vr_cnt - vr0);
    end
    checks++;
    if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin
      errors++;
      $display("FAIL glitch_flags: got fe=%0d ov=%0d expected 0/0",
               fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_framing();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    int fe0, vr0;
    fe0 = fe_cnt;
    vr0 = vr_cnt;
    @(negedge Clk);
    RXD = 1'b0;
    repeat (20 * BC) @(negedge Clk);
    RXD = 1'b1;
    repeat (2 * BC) @(negedge Clk);
    checks++;
    if (fe_cnt - fe0 !== 1 || vr_cnt - vr0 !== 0) begin
      errors++;
      $display("FAIL break_once: got fe=%0d vr=%0d expected 1/0",
               fe_cnt - fe0, vr_cnt - vr0);
    end
    fe0 = fe_cnt;
    fork
      drive_frame(8'h55, 1'b0);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    checks++;
    if ({fe, va} !== 2'b10) begin
      errors++;
      $display("FAIL frame_err: got fe/valid %b expected 10", {fe, va});
    end
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0);
    end
    exp_q.push_back(8'h12);
    fork
      drive_frame(8'h12, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    take_exp(e);
    checks++;
    if ({va, fe, d} !== {2'b10, e}) begin
      errors++;
      $display("FAIL frame_next: got %b/%b/%h expected 1/0/%h",
               va, fe, d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    int fe0, ov0, vr0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vr0 = vr_cnt;
    fork
      drive_frame(8'hF0, 1'b1);
      begin
        wait (RXD === 1'b0);
        repeat (5 * BC + HALF) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if ({Data_Out, Data_Valid, Frame_Error, Overrun} !== 11'd0) begin
          errors++;
          $display("FAIL rstmid_outputs: got %h/%b%b%b expected 00/000",
                   Data_Out, Data_Valid, Frame_Error, Overrun);
        end
      end
    join
    repeat (2 * BC) @(negedge Clk);
    checks++;
    if (vr_cnt - vr0 !== 0 || fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got vr=%0d fe=%0d ov=%0d expected 0",
               vr_cnt - vr0, fe_cnt - fe0, ov_cnt - ov0);
    end
    exp_q.push_back(8'h3C);
    fork
      drive_frame(8'h3C, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    take_exp(e);
    checks++;
    if ({vb, va, d} !== {2'b01, e}) begin
      errors++;
      $display("FAIL rstmid_next: got %b%b/%h expected 01/%h",
               vb, va, d, e);
    end
    Data_Ack = 1'b1;
    @(negedge Clk);
    Data_Ack = 1'b0;
  endtask

  task automatic test_overrun();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    exp_q.push_back(8'h11);
    fork
      drive_frame(8'h11, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    take_exp(e);
    checks++;
    if ({va, d} !== {1'b1, e}) begin
      errors++;
      $display("FAIL ovr_first: got %b/%h expected 1/%h", va, d, e);
    end
    fork
      drive_frame(8'h22, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
    join
    checks++;
    if ({ov, va, d} !== {2'b11, 8'h11}) begin
      errors++;
      $display("FAIL ovr_drop: got %b%b/%h expected 11/11", ov, va, d);
    end
    exp_q.push_back(8'h22);
    fork
      drive_frame(8'h22, 1'b1);
      wait_frame(1'b1, vb, va, d, fe, ov);
    join
    take_exp(e);
    checks++;
    if ({ov, va, d} !== {2'b01, e}) begin
      errors++;
      $display("FAIL ovr_ack_same: got %b%b/%h expected 01/%h",
               ov, va, d, e);
    end
    Data_Ack = 1'b1;
    @(negedge Clk);
    Data_Ack = 1'b0;
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    logic vb, va, fe, ov;
    logic [7:0] d, e;
    exp_q.push_back(8'hAB);
    fork
      drive_frame(8'hAB, 1'b1);
      wait_frame(1'b0, vb, va, d, fe, ov);
      begin
        wait (RXD === 1'b0);
        @(posedge Clk);
        repeat (HALF + 4 * BC) @(posedge Clk);
        @(negedge Clk);
        RXD = ~RXD;
        @(negedge Clk);
        RXD = ~RXD;
      end
    join
    take_exp(e);
    checks++;
    if ({va, d} !== {1'b1, e}) begin
      errors++;
      $display("FAIL majority: got %b/%h expected 1/%h", va, d, e);
    end
    Data_Ack = 1'b1;
    @(negedge Clk);
    Data_Ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_overrun();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d left expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the microcontroller's RX path. Deserializes 8N1 frames from the `RXD` pin and presents each byte on a valid/ack handshake to the RX DMA, which writes it to data memory. Sits between the top-level `RXD` pad and the DMA controller.

## Interface
Parameters:
- `FREQ_CLK`, 100000000: system clock frequency in Hz.
- `TX_SPEED`, 115200: baud rate.
- `BIT_CYCLES`, FREQ_CLK/TX_SPEED (868): clocks per bit. Derived; not overridden independently.

Ports:
- `Clk` in 1: system clock. One clock domain only.
- `Rst` in 1: reset, synchronous, active-high.
- `RXD` in 1: asynchronous serial input; idles high.
- `Data_Out` out 8: received byte, LSB first on the line.
- `Data_Valid` out 1: `Data_Out` holds an unconsumed byte.
- `Data_Ack` in 1: DMA consumes the byte.
- `Frame_Error` out 1: one-cycle pulse when the stop bit samples 0.
- `Overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- `RXD` passes through a 2-flop synchronizer, reset to 1. Falling edge detection runs on the synchronized line: previous value 1, current value 0.
- `HALF` = BIT_CYCLES/2 (434). The 10-bit counter `cnt` clears on every state change.
- IDLE: a falling edge moves the block to START.
- START: when cnt == HALF-1, sample the line.
  - 0: go to DATA.
  - 1: glitch; return to IDLE with no flags.
- DATA: when cnt == BIT_CYCLES-1, sample the line and shift it into bit[idx]. `idx` runs 0..7. After idx 7, go to STOP.
- STOP: when cnt == BIT_CYCLES-1, sample the line.
  - 1: deliver the byte and return to IDLE.
  - 0: pulse `Frame_Error`, discard the byte, and return to IDLE.
  - Returning at mid-stop leaves half a bit of margin, so back-to-back frames are accepted.
- After a frame error, IDLE needs a fresh falling edge. A held-low break line produces exactly one error and no further frames.
- Byte delivery:
  - If `Data_Valid` is 0, or `Data_Ack` is high in the same cycle: load `Data_Out` and set `Data_Valid` = 1.
  - Otherwise: keep the old byte, drop the new one, and pulse `Overrun`.
- Handshake: a transfer occurs on a cycle with `Data_Valid` && `Data_Ack`. `Data_Valid` clears the next cycle unless a new byte loads in the same cycle. `Data_Out` is stable while `Data_Valid` is high. `Data_Ack` while not valid is ignored.

## Timing
- Reset values: `Data_Out` = 0, `Data_Valid` = 0, `Frame_Error` = 0, `Overrun` = 0, state = IDLE, synchronizer = 1, shift register = 0.
- `Rst` mid-frame aborts the frame immediately. No valid or flag pulse is produced, and any pending byte is lost.
- Latency: `Data_Valid` rises on the clock edge HALF + 9·BIT_CYCLES + 3 = 8249 cycles after the first `Clk` edge at which `RXD` is sampled low. That is 2 synchronizer cycles, the start/data/stop sampling, and 1 output register.
- `Frame_Error` and `Overrun` are registered and pulse on the same cycle `Data_Valid` would have risen.
- All outputs are registered. There is no combinational path from `Data_Ack` to any output.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - A 3-deep history of the synchronized line is kept.
  - Each sample (start, data, stop) is the majority of the last 3 synchronized values at the sample point.
  - A single-cycle glitch at a sample point is rejected. Sample timing is unchanged.
- Undefined: each sample is the single synchronized value at the sample point.

## Structure
- `global_pkg` gains:
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `FREQ_CLK` (100000000) and `TX_SPEED` (115200), shared with the transmitter and benches.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer, previous-value register, and falling-edge output. Under `UART_RX_MAJORITY_EN` it also holds the 3-sample history and the majority output.
- The FSM, counter, shift register and handshake live in `uart_rx`.

## Test plan
- Single byte: 0xAB at 115200 baud, `Data_Ack` held 0.
  - `Data_Valid` rises at +8249 cycles with `Data_Out` = 0xAB.
  - `Data_Valid` stays high until `Data_Ack`, then clears the next cycle.
- Back-to-back: 0xAB then 0xCD, with the second start bit 1 clock after the stop bit, each acked 1 cycle after valid.
  - Two transfers, 0xAB then 0xCD; no `Frame_Error`, no `Overrun`.
- Glitch: `RXD` low for 200 cycles, then high.
  - FSM returns to IDLE; no `Data_Valid` and no flags.
- Framing: 0x55 sent with stop bit 0.
  - `Frame_Error` pulses once; `Data_Valid` stays 0.
  - A following valid 0x12 frame is received correctly.
- Overrun: 0x11 and 0x22 sent without ack.
  - `Overrun` pulses at the second frame's completion; `Data_Out` stays 0x11.
  - Ack asserted on the exact completion cycle instead: 0x22 loads, `Data_Valid` stays high, no `Overrun`.
- Reset mid-frame: `Rst` for 1 cycle during data bit 4 of 0xF0.
  - No `Data_Valid`; all outputs 0.
  - The next frame, 0x3C, is received correctly.
  - With `UART_RX_MAJORITY_EN`: a 1-cycle inverted pulse on a bit centre of 0xAB still yields 0xAB.
